// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared sizing constants for the architectural register file
package register_file_pkg;
    localparam int ROB_WIDTH      = 4;
    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [REG_ADDR_WIDTH-1:0] X0_IDX = '0;
endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - commit, rename, flush and read-port signals of the register file
interface register_file_if #(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH
);
    import register_file_pkg::*;

    logic                      clear;
    logic                      regUpdateValid;
    logic [REG_ADDR_WIDTH-1:0] regUpdateDest;
    logic [31:0]               regValue;
    logic [ROB_WIDTH-1:0]      regUpdateRobId;
    logic                      renameValid;
    logic [REG_ADDR_WIDTH-1:0] renameDest;
    logic [ROB_WIDTH-1:0]      renameRobId;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic                      rs1Dirty;
    logic [ROB_WIDTH-1:0]      rs1Dep;
    logic [31:0]               rs1Value;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      rs2Dirty;
    logic [ROB_WIDTH-1:0]      rs2Dep;
    logic [31:0]               rs2Value;

    modport master (
        output clear, regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        output renameValid, renameDest, renameRobId, rs1, rs2,
        input  rs1Dirty, rs1Dep, rs1Value, rs2Dirty, rs2Dep, rs2Value
    );

    modport slave (
        input  clear, regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        input  renameValid, renameDest, renameRobId, rs1, rs2,
        output rs1Dirty, rs1Dep, rs1Value, rs2Dirty, rs2Dep, rs2Value
    );
endinterface

// File: rtl/register_file_reg_read_port.sv
// rtl/register_file_reg_read_port.sv - one combinational operand lookup with same-cycle commit forward
module reg_read_port
    import register_file_pkg::*;
#(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic                      busy,
    input  logic [ROB_WIDTH-1:0]      tag,
    input  logic [31:0]               value,
    input  logic                      commit_valid,
    input  logic [REG_ADDR_WIDTH-1:0] commit_dest,
    input  logic [ROB_WIDTH-1:0]      commit_rob_id,
    input  logic [31:0]               commit_value,
    output logic                      dirty,
    output logic [ROB_WIDTH-1:0]      dep,
    output logic [31:0]               rd_value
);
    always_comb begin
        dirty    = 1'b0;
        dep      = '0;
        rd_value = value;
        if (rs == X0_IDX) begin
            rd_value = '0;
        end else if (busy) begin
            // The producer retiring right now resolves the dependency this cycle.
            if (commit_valid && commit_dest == rs && tag == commit_rob_id) begin
                rd_value = commit_value;
            end else begin
                dirty = 1'b1;
                dep   = tag;
            end
        end
    end
endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 architectural register file with ROB rename tags and commit retirement
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH
) (
    input  logic            clockIn,
    input  logic            resetIn,
    register_file_if.slave  rf
);
    logic [31:0]          value_q [REG_COUNT];
    logic [31:0]          value_d [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic [ROB_WIDTH-1:0] tag_q   [REG_COUNT];
    logic [ROB_WIDTH-1:0] tag_d   [REG_COUNT];

    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (rf.regUpdateValid && rf.regUpdateDest != X0_IDX) begin
            value_d[rf.regUpdateDest] = rf.regValue;
            // A mismatched tag means a younger producer owns the register; keep it busy.
            if (busy_q[rf.regUpdateDest] && tag_q[rf.regUpdateDest] == rf.regUpdateRobId) begin
                busy_d[rf.regUpdateDest] = 1'b0;
            end
        end
        if (rf.clear) begin
            busy_d = '0;
        end else if (rf.renameValid && rf.renameDest != X0_IDX) begin
            busy_d[rf.renameDest] = 1'b1;
            tag_d[rf.renameDest]  = rf.renameRobId;
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            value_q <= '{default: '0};
            busy_q  <= '0;
            tag_q   <= '{default: '0};
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    reg_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs1_port (
        .rs            (rf.rs1),
        .busy          (busy_q[rf.rs1]),
        .tag           (tag_q[rf.rs1]),
        .value         (value_q[rf.rs1]),
        .commit_valid  (rf.regUpdateValid),
        .commit_dest   (rf.regUpdateDest),
        .commit_rob_id (rf.regUpdateRobId),
        .commit_value  (rf.regValue),
        .dirty         (rf.rs1Dirty),
        .dep           (rf.rs1Dep),
        .rd_value      (rf.rs1Value)
    );

    reg_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs2_port (
        .rs            (rf.rs2),
        .busy          (busy_q[rf.rs2]),
        .tag           (tag_q[rf.rs2]),
        .value         (value_q[rf.rs2]),
        .commit_valid  (rf.regUpdateValid),
        .commit_dest   (rf.regUpdateDest),
        .commit_rob_id (rf.regUpdateRobId),
        .commit_value  (rf.regValue),
        .dirty         (rf.rs2Dirty),
        .dep           (rf.rs2Dep),
        .rd_value      (rf.rs2Value)
    );
endmodule
